// File: rtl/shield_pkg.sv
// Shared types for the shield controller and the shield renderer:
// direction encoding, controller FSM states and press-resolution helper.
package shield_pkg;

    // Direction encoding driven onto the renderer's rotate input
    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        RIGHT = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PENDING  = 2'b01,
        COOLDOWN = 2'b10
    } state_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } press_t;

    // Pick a single winner among same-cycle press events: up > down > left > right
    function automatic press_t resolve_press(input logic up,
                                             input logic down,
                                             input logic left,
                                             input logic right);
        press_t res;
        res.valid = up | down | left | right;
        res.dir   = UP;
        if (up) begin
            res.dir = UP;
        end else if (down) begin
            res.dir = DOWN;
        end else if (left) begin
            res.dir = LEFT;
        end else if (right) begin
            res.dir = RIGHT;
        end
        return res;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one
// raw push button. press_out pulses for one cycle when the debounced level
// rises; a release produces no pulse.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 742500
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic level_out,
    output logic press_out
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] count;
    logic          differ;
    logic          expire;

    assign differ = (sync_p1 != level_out);
    // Count reaches its last value on the DEBOUNCE_CYCLES-th differing cycle
    assign expire = differ && (count == LAST);

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive disagreeing cycles; flip the level when the run completes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count     <= '0;
            level_out <= 1'b0;
            press_out <= 1'b0;
        end else begin
            press_out <= expire && !level_out;
            if (!differ) begin
                count <= '0;
            end else if (expire) begin
                count     <= '0;
                level_out <= ~level_out;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shield_controller.sv
// Shield direction controller: debounces four buttons, turns presses into a
// pending direction and applies it only right after a frame start so the
// rendered shield never tears, then ignores presses for a few frames.
module shield_controller
    import shield_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 742500,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_up_in,
    input  logic       btn_down_in,
    input  logic       btn_left_in,
    input  logic       btn_right_in,
    input  logic       new_frame_in,
    output logic [1:0] rotate_out,
    output logic       changed_out,
    output logic       busy_out
);

    // A zero cooldown still needs a one-bit counter to keep the logic legal
    localparam int                 COOL_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [COOL_W-1:0]  COOL_LOAD = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [COOL_W-1:0]  COOL_ONE  = COOL_W'(1);

    logic [3:0]  unused_level;
    logic        press_up;
    logic        press_down;
    logic        press_left;
    logic        press_right;
    press_t      press;

    state_t              state;
    state_t              state_next;
    dir_t                pending;
    dir_t                pending_next;
    dir_t                rotate;
    dir_t                rotate_next;
    logic                changed_next;
    logic [COOL_W-1:0]   cool;
    logic [COOL_W-1:0]   cool_next;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (btn_up_in),
        .level_out(unused_level[0]),
        .press_out(press_up)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (btn_down_in),
        .level_out(unused_level[1]),
        .press_out(press_down)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (btn_left_in),
        .level_out(unused_level[2]),
        .press_out(press_left)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .raw_in   (btn_right_in),
        .level_out(unused_level[3]),
        .press_out(press_right)
    );

    assign press      = resolve_press(press_up, press_down, press_left, press_right);
    assign rotate_out = rotate;
    assign busy_out   = (state != IDLE);

    // Next-state logic: capture presses, commit on frame start, count down cooldown
    always_comb begin
        state_next   = state;
        pending_next = pending;
        rotate_next  = rotate;
        changed_next = 1'b0;
        cool_next    = cool;
        case (state)
            IDLE: begin
                // A coincident frame start is ignored here; the change waits a frame
                if (press.valid && (press.dir != rotate)) begin
                    pending_next = press.dir;
                    state_next   = PENDING;
                end
            end
            PENDING: begin
                if (press.valid && (press.dir == rotate)) begin
                    pending_next = press.dir;
                    state_next   = IDLE;
                end else if (new_frame_in) begin
                    // A press in the same cycle as the frame start overrides the stored one
                    rotate_next  = press.valid ? press.dir : pending;
                    pending_next = press.valid ? press.dir : pending;
                    changed_next = 1'b1;
                    cool_next    = COOL_LOAD;
                    state_next   = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                end else if (press.valid) begin
                    pending_next = press.dir;
                end
            end
            COOLDOWN: begin
                // Presses are dropped here, not queued
                if (new_frame_in) begin
                    if (cool > COOL_ONE) begin
                        cool_next = cool - 1'b1;
                    end else begin
                        cool_next  = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller state, direction and pulse registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pending     <= UP;
            rotate      <= UP;
            changed_out <= 1'b0;
            cool        <= '0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            rotate      <= rotate_next;
            changed_out <= changed_next;
            cool        <= cool_next;
        end
    end

endmodule

// File: doc/shield_controller.md
SHIELD_CONTROLLER -- requirements
Module: shield_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 742500, SHALL set the consecutive stable cycles needed to accept a button level change (10 ms at 74.25 MHz).
REQ-002 Parameter COOLDOWN_FRAMES, default 4, SHALL set the frames during which new presses are dropped after a direction change.
REQ-003 clk_in  input  1  system clock; the block SHALL use one clock.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 btn_up_in, btn_down_in, btn_left_in, btn_right_in  input  1 each  raw asynchronous push buttons, active-high.
REQ-006 new_frame_in  input  1  one-cycle pulse at frame start (hcount=0, vcount=0).
REQ-007 rotate_out  output  2  shield direction: 2'b00 up, 2'b01 down, 2'b10 right, 2'b11 left; drives the shield renderer's rotate input.
REQ-008 changed_out  output  1  one-cycle pulse on the cycle rotate_out takes a new value.
REQ-009 busy_out  output  1  high in PENDING or COOLDOWN.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose output level flips only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the count.
REQ-011 A press event SHALL be a one-cycle pulse on the debounced level's rising edge; releases SHALL generate no event.
REQ-012 Simultaneous press events SHALL resolve by priority up > down > left > right; only the winner is used.
REQ-013 FSM states SHALL be IDLE, PENDING, COOLDOWN.
REQ-014 IDLE: a press event whose direction differs from rotate_out SHALL store it in the pending register and go to PENDING; a press equal to rotate_out SHALL be ignored.
REQ-015 PENDING: a new press event SHALL overwrite the pending direction; if it equals rotate_out, go to IDLE with no change.
REQ-016 PENDING with new_frame_in: the cycle after, rotate_out SHALL equal the pending direction, changed_out SHALL pulse, the cooldown counter SHALL load COOLDOWN_FRAMES, and the state SHALL become COOLDOWN, or IDLE if COOLDOWN_FRAMES=0.
REQ-017 A press event coinciding with new_frame_in in PENDING SHALL be taken into account before the update (the new press wins); in IDLE the coincident new_frame_in SHALL be ignored and the change waits for the next frame.
REQ-018 COOLDOWN: press events SHALL be dropped, not queued; each new_frame_in SHALL decrement the counter; on reaching 0 the state SHALL become IDLE.
REQ-019 rotate_out SHALL change only in the cycle after a new_frame_in, so the rendered shield never tears mid-frame.
REQ-020 The cooldown counter SHALL be $clog2(COOLDOWN_FRAMES+1) bits wide and never wrap below 0; the debounce counter SHALL saturate at DEBOUNCE_CYCLES.

Reset
REQ-021 On rst_in: rotate_out=2'b00, changed_out=0, busy_out=0, state IDLE, pending=2'b00, all counters 0, synchronizer and debounced levels 0.
REQ-022 Reset mid-PENDING or mid-COOLDOWN SHALL discard the pending direction and the remaining cooldown, with no changed_out pulse.
REQ-023 A button held through reset deassertion SHALL produce one press event after DEBOUNCE_CYCLES.

Structure
REQ-024 Package shield_pkg SHALL hold the direction enum (UP, DOWN, RIGHT, LEFT with the REQ-007 encodings) and the FSM state enum; the shield renderer SHALL import the same direction type.
REQ-025 Sub-module debouncer (synchronizer plus counter, parameter DEBOUNCE_CYCLES, ports clk_in, rst_in, raw_in, level_out, press_out) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2)
REQ-026 Hold btn_left_in 20 cycles, then pulse new_frame_in -> rotate_out=2'b11 and changed_out=1 on the cycle after the pulse; busy_out=1 until 2 further new_frame_in pulses.
REQ-027 Glitch btn_right_in high for 3 cycles -> no press event, state stays IDLE, rotate_out stays 2'b00.
REQ-028 Press up and right in the same cycle from reset -> ignored (up equals the current 2'b00), state stays IDLE; press down and right together -> pending=2'b01.
REQ-029 In PENDING(left), press right in the same cycle as new_frame_in -> rotate_out=2'b10 on the next cycle.
REQ-030 During COOLDOWN, press down -> dropped; after cooldown ends, rotate_out is unchanged and there is no changed_out pulse.
REQ-031 Assert rst_in in PENDING, then pulse new_frame_in -> rotate_out=2'b00, changed_out stays 0, busy_out=0.
